// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the rv32i core.
// Optional trap-and-halt on illegal encodings is enabled by defining PC_SEQ_ILLEGAL_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic                  i_imem_ready,
  input  logic                  i_dmem_ready,
  output logic                  o_imem_req,
  output logic                  o_ir_load,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic                  o_reg_write,
  output logic [1:0]            o_wb_sel,
  output logic [2:0]            o_jump_type,
  output logic                  o_update_pc,
  output logic                  o_illegal,
  output logic [DATA_WIDTH-1:0] o_instr_count
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] JtNone = 3'd0;
  localparam logic [2:0] JtIf0  = 3'd1;
  localparam logic [2:0] JtIf1  = 3'd2;
  localparam logic [2:0] JtJal  = 3'd3;
  localparam logic [2:0] JtJalr = 3'd4;
  localparam logic [2:0] JtZero = 3'd5;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_UPDATE, S_HALT
  } state_e;

  state_e                r_state;
  logic                  r_imem_req;
  logic                  r_ir_load;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic                  r_reg_write;
  logic [1:0]            r_wb_sel;
  logic [2:0]            r_jump_type;
  logic                  r_update_pc;
  logic [DATA_WIDTH-1:0] r_instr_count;
  logic                  r_is_load;
  logic                  r_is_store;
  logic                  r_no_wb;

  logic       w_legal_op;
  logic       w_is_branch;
  logic       w_bad_f3;
  logic       w_illegal;
  logic       w_no_wb;
  logic [2:0] w_jump;
  logic [1:0] w_wb_sel;

  always_comb begin
    w_is_branch = (i_opcode == OpBranch);
    w_bad_f3    = w_is_branch && (i_funct3 == 3'b010 || i_funct3 == 3'b011);
    w_legal_op  = 1'b0;
    unique case (i_opcode)
      OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
      OpStore, OpImm, OpReg, OpFence, OpSystem: w_legal_op = 1'b1;
      default:                                  w_legal_op = 1'b0;
    endcase
    w_illegal = !w_legal_op || w_bad_f3;

    w_jump = JtNone;
    if (!w_illegal) begin
      if (i_opcode == OpJal) begin
        w_jump = JtJal;
      end else if (i_opcode == OpJalr) begin
        w_jump = JtJalr;
      end else if (w_is_branch) begin
        // BEQ/BLT/BLTU take the branch on a true compare; BNE/BGE/BGEU on a false one.
        w_jump = i_funct3[0] ? JtIf0 : JtIf1;
      end
    end

    // Illegal encodings fall through as a NOP with no writeback.
    w_no_wb = w_illegal || w_is_branch || (i_opcode == OpStore) ||
              (i_opcode == OpFence) || (i_opcode == OpSystem);

    w_wb_sel = 2'd0;
    if (i_opcode == OpLoad) begin
      w_wb_sel = 2'd1;
    end else if (i_opcode == OpJal || i_opcode == OpJalr) begin
      w_wb_sel = 2'd2;
    end
  end

`ifdef PC_SEQ_ILLEGAL_TRAP_EN
  logic r_illegal;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_RESET;
      r_imem_req    <= 1'b0;
      r_ir_load     <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_wb_sel      <= 2'd0;
      r_jump_type   <= JtZero;
      r_update_pc   <= 1'b0;
      r_instr_count <= '0;
      r_is_load     <= 1'b0;
      r_is_store    <= 1'b0;
      r_no_wb       <= 1'b0;
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
      r_illegal     <= 1'b0;
`endif
    end else begin
      r_ir_load   <= 1'b0;
      r_reg_write <= 1'b0;
      r_update_pc <= 1'b0;
      unique case (r_state)
        S_RESET: begin
          // First cycle out of reset pulses update_pc to load PC = 0, then fetch.
          if (!r_update_pc) begin
            r_update_pc <= 1'b1;
            r_jump_type <= JtZero;
          end else begin
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_imem_ready) begin
            r_imem_req <= 1'b0;
            r_ir_load  <= 1'b1;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_jump_type <= w_jump;
          r_is_load   <= (i_opcode == OpLoad) && !w_illegal;
          r_is_store  <= (i_opcode == OpStore) && !w_illegal;
          r_no_wb     <= w_no_wb;
          r_wb_sel    <= w_wb_sel;
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
`else
          r_state <= S_EXEC;
`endif
        end
        S_EXEC: begin
          if (r_is_load || r_is_store) begin
            r_dmem_req <= 1'b1;
            r_dmem_we  <= r_is_store;
            r_state    <= S_MEM;
          end else if (r_no_wb) begin
            r_update_pc   <= 1'b1;
            r_instr_count <= r_instr_count + DATA_WIDTH'(1);
            r_state       <= S_UPDATE;
          end else begin
            r_reg_write <= 1'b1;
            r_state     <= S_WB;
          end
        end
        S_MEM: begin
          if (i_dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_is_load) begin
              r_reg_write <= 1'b1;
              r_state     <= S_WB;
            end else begin
              r_update_pc   <= 1'b1;
              r_instr_count <= r_instr_count + DATA_WIDTH'(1);
              r_state       <= S_UPDATE;
            end
          end
        end
        S_WB: begin
          r_update_pc   <= 1'b1;
          r_instr_count <= r_instr_count + DATA_WIDTH'(1);
          r_state       <= S_UPDATE;
        end
        S_UPDATE: begin
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_RESET;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_ir_load     = r_ir_load;
  assign o_dmem_req    = r_dmem_req;
  assign o_dmem_we     = r_dmem_we;
  assign o_reg_write   = r_reg_write;
  assign o_wb_sel      = r_wb_sel;
  assign o_jump_type   = r_jump_type;
  assign o_update_pc   = r_update_pc;
  assign o_instr_count = r_instr_count;
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
  assign o_illegal     = r_illegal;
`else
  assign o_illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: randomized instruction stream against a table-driven model.
module tb_pc_sequencer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          o_imem_req, o_ir_load, o_dmem_req, o_dmem_we, o_reg_write;
  logic [1:0]    o_wb_sel;
  logic [2:0]    o_jump_type;
  logic          o_update_pc, o_illegal;
  logic [DW-1:0] o_instr_count;

  pc_sequencer #(.DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_opcode     (opcode),
    .i_funct3     (funct3),
    .i_imem_ready (imem_ready),
    .i_dmem_ready (dmem_ready),
    .o_imem_req   (o_imem_req),
    .o_ir_load    (o_ir_load),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_reg_write  (o_reg_write),
    .o_wb_sel     (o_wb_sel),
    .o_jump_type  (o_jump_type),
    .o_update_pc  (o_update_pc),
    .o_illegal    (o_illegal),
    .o_instr_count(o_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  jt;
    logic [1:0]  wb_sel;
    int          wr;
    int          dreq;
    bit          we;
    logic [31:0] count;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned model_count = 0;

  logic [6:0] legal_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                                 7'b1110011};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Expected response of one instruction, straight from the decode and state-flow tables.
  function automatic exp_t predict(input logic [6:0] op, input logic [2:0] f3,
                                   input int wi, input int wd);
    exp_t e;
    bit legal = 1'b0;
    bit branch, is_load, is_store, mem, wb;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    branch = (op == 7'b1100011);
    if (branch && (f3 == 3'd2 || f3 == 3'd3)) legal = 1'b0;
    is_load  = legal && (op == 7'b0000011);
    is_store = legal && (op == 7'b0100011);
    mem = is_load || is_store;
    wb  = legal && !(branch || is_store || op == 7'b0001111 || op == 7'b1110011);
    e.jt = 3'd0;
    if (legal && op == 7'b1101111) e.jt = 3'd3;
    else if (legal && op == 7'b1100111) e.jt = 3'd4;
    else if (legal && branch) e.jt = (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6) ? 3'd2 : 3'd1;
    e.wb_sel = is_load ? 2'd1 : ((op == 7'b1101111 || op == 7'b1100111) ? 2'd2 : 2'd0);
    e.wr     = wb ? 1 : 0;
    e.dreq   = mem ? wd + 1 : 0;
    e.we     = is_store;
    e.lat    = (wi + 1) + 1 + 1 + (mem ? wd + 1 : 0) + (wb ? 1 : 0) + 1;
    e.count  = 32'd0;
    return e;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e.jt = 3'd5; e.wb_sel = 2'd0; e.wr = 0; e.dreq = 0; e.we = 1'b0; e.count = 32'd0; e.lat = 1;
    return e;
  endfunction

  // Monitor: accumulates activity per instruction and checks it on every update_pc pulse.
  bit         rst_seen = 1'b1;
  int         cyc = 0, wr_cnt = 0, dreq_cnt = 0;
  bit         we_seen = 1'b0, jt_track = 1'b0, jt_stable = 1'b1, start_next = 1'b0;
  bit         prev_upd = 1'b0;
  logic [1:0] wsel = 2'd0;
  logic [2:0] jt_prev = 3'd0;

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      check("reset_outputs", {o_imem_req, o_ir_load, o_dmem_req, o_dmem_we, o_reg_write,
                              o_wb_sel, o_update_pc, o_illegal}, 0);
      check("reset_jump_type", o_jump_type, 5);
      check("reset_count", o_instr_count, 0);
      cyc = 0; wr_cnt = 0; dreq_cnt = 0; we_seen = 0;
      jt_track = 0; jt_stable = 1; start_next = 0; prev_upd = 0;
    end else begin
      cyc++;
      if (o_reg_write === 1'b1) begin wr_cnt++; wsel = o_wb_sel; end
      if (o_dmem_req === 1'b1) begin dreq_cnt++; if (o_dmem_we === 1'b1) we_seen = 1; end
      if (jt_track && o_jump_type !== jt_prev) jt_stable = 0;
      jt_prev = o_jump_type;
      if (start_next) begin jt_track = 1; start_next = 0; end
      if (o_ir_load === 1'b1) start_next = 1;
      if (o_update_pc === 1'b1) begin
        check("update_pc_not_back_to_back", prev_upd, 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update_pc actual 1 required 0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("jump_type", o_jump_type, e.jt);
          check("instr_count", o_instr_count, e.count);
          check("latency", cyc, e.lat);
          check("reg_write_cycles", wr_cnt, e.wr);
          if (e.wr != 0) check("wb_sel", wsel, e.wb_sel);
          check("dmem_req_cycles", dreq_cnt, e.dreq);
          check("dmem_we", we_seen, e.we);
          check("jump_type_stable", jt_stable, 1);
          check("illegal_flag_low", o_illegal, 0);
        end
        cyc = 0; wr_cnt = 0; dreq_cnt = 0; we_seen = 0;
        jt_track = 0; jt_stable = 1; start_next = 0;
      end
      prev_upd = (o_update_pc === 1'b1);
    end
  end

  task automatic wait_req(input bit dmem, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((dmem ? o_dmem_req : o_imem_req) === 1'b1) begin ok = 1'b1; return; end
    end
    checks++; errors++;
    $display("FAIL %s_timeout actual 0 required 1", dmem ? "dmem_req" : "imem_req");
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_count = 0;
    sb.push_back(reset_rec());
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wi,
                           input int wd, input bit abort_in_mem);
    bit   ok;
    exp_t e;
    wait_req(1'b0, ok);
    if (!ok) return;
    repeat (wi) begin imem_ready = 1'b0; @(negedge clk); end
    imem_ready = 1'b1;
    opcode = op;
    funct3 = f3;
    e = predict(op, f3, wi, wd);
    model_count++;
    e.count = model_count;
    sb.push_back(e);
    @(negedge clk);
    imem_ready = 1'b0;
    if (e.dreq != 0) begin
      wait_req(1'b1, ok);
      if (!ok) return;
      if (abort_in_mem) begin
        void'(sb.pop_back());
        do_reset(3);
        return;
      end
      repeat (wd) begin dmem_ready = 1'b0; @(negedge clk); end
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    do_reset(3);

    run_instr(7'b0010011, 3'b000, 0, 0, 0);  // ADDI
    run_instr(7'b0000011, 3'b010, 0, 3, 0);  // LW, data memory slow
    run_instr(7'b0000011, 3'b010, 0, 0, 0);  // LW, minimum latency
    run_instr(7'b1100011, 3'b001, 1, 0, 0);  // BNE
    run_instr(7'b1100111, 3'b000, 0, 0, 0);  // JALR
    run_instr(7'b1101111, 3'b000, 2, 0, 0);  // JAL
    run_instr(7'b0100011, 3'b010, 0, 2, 0);  // SW
    run_instr(7'b1100011, 3'b110, 0, 0, 0);  // BLTU
`ifndef PC_SEQ_ILLEGAL_TRAP_EN
    run_instr(7'b0000000, 3'b000, 0, 0, 0);  // illegal opcode as NOP
    run_instr(7'b1100011, 3'b010, 0, 0, 0);  // illegal branch funct3 as NOP
`endif

    for (int n = 0; n < 200; n++) begin
      op = legal_ops[$urandom_range(0, 10)];
      f3 = 3'($urandom_range(0, 7));
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
      if (op == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd0;
`else
      if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b1111111;
`endif
      run_instr(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    run_instr(7'b0000011, 3'b010, 0, 5, 1);  // LW aborted by reset in S_MEM
    run_instr(7'b0010011, 3'b000, 0, 0, 0);
    run_instr(7'b1100011, 3'b000, 1, 0, 0);

    for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

`ifdef PC_SEQ_ILLEGAL_TRAP_EN
    begin
      bit ok;
      wait_req(1'b0, ok);
      if (ok) begin
        imem_ready = 1'b1;
        opcode = 7'b0000000;
        funct3 = 3'b000;
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("trap_illegal", o_illegal, 1);
        check("trap_no_fetch", o_imem_req, 0);
        check("trap_count_frozen", o_instr_count, model_count);
      end
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
